// File: rtl/pkg_cpu_typedefs.sv
// ---------------------------------------------------------------------------
// pkg_cpu_typedefs
// Shared types for the CPU memory-bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, FETCH, DATA, RESP)
//   arb_port_t  : requesting port identity (PORT_IF, PORT_MEM)
//   other_port  : the opposite port, used by the rotating-priority rule
// ---------------------------------------------------------------------------
package pkg_cpu_typedefs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_IF  = 1'b0,
      PORT_MEM = 1'b1
   } arb_port_t;

   function automatic arb_port_t other_port(input arb_port_t p);
      return (p == PORT_IF) ? PORT_MEM : PORT_IF;
   endfunction

endpackage

// File: rtl/cpu_mem_arb_timer.sv
// ---------------------------------------------------------------------------
// cpu_mem_arb_timer
// Bus-wait counter for the arbiter timeout. Only instantiated when
// CPU_MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : grant strobe; clears the count for the new transaction
//   i_run       : arbiter is waiting on the bus (FETCH or DATA)
//   i_ack       : bus_ack from the interconnect
//   o_expired   : the MAX_WAIT-th waiting cycle passed without bus_ack
// ---------------------------------------------------------------------------
module cpu_mem_arb_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_run,
   input  logic i_ack,
   output logic o_expired
);
   // Wide enough to hold MAX_WAIT-1, the value seen in the last waiting cycle.
   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_start) begin
         r_count <= '0;
      end else if (i_run && !i_ack) begin
         r_count <= r_count + CW'(1);
      end
   end

   // A bus_ack arriving in the final cycle still wins over the timeout.
   assign o_expired = i_run & ~i_ack & (r_count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one single-ported memory bus between the instruction-fetch (IF)
// and data-memory (MEM) pipeline stages. One bus transaction at a time,
// registered req/ack handshake per port, rotating priority on contention.
//
// Optional feature macro: CPU_MEM_ARB_TIMEOUT_EN
//   defined   : a transaction waiting MAX_WAIT cycles without bus_ack is
//               completed with zero read data and sets sticky bus_err.
//   undefined : waits indefinitely for bus_ack; bus_err tied to 0.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   if_req/if_addr/if_kill   : fetch request, address, branch flush
//   if_rdata/if_ack          : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_be       : data request, store strobe, byte enables
//   dm_addr/dm_wdata         : data address, store data
//   dm_rdata/dm_ack          : load data, one-cycle completion pulse
//   bus_req/bus_we/bus_be    : bus transaction active, write, byte enables
//   bus_addr/bus_wdata       : bus address, write data
//   bus_rdata/bus_ack        : bus read data, single-cycle completion
//   bus_err                  : sticky timeout flag
// ---------------------------------------------------------------------------
module cpu_mem_arbiter
   import pkg_cpu_typedefs::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   input  logic                  if_kill,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [DATA_W/8-1:0]   dm_be,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [DATA_W-1:0]     dm_wdata,
   output logic [DATA_W-1:0]     dm_rdata,
   output logic                  dm_ack,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [DATA_W/8-1:0]   bus_be,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic [DATA_W-1:0]     bus_rdata,
   input  logic                  bus_ack,
   output logic                  bus_err
);
   localparam int BE_W = DATA_W / 8;

   if (MAX_WAIT < 1) begin : g_max_wait_check
      $error("cpu_mem_arbiter: MAX_WAIT must be >= 1");
   end

   arb_state_t          r_state, w_state_nxt;
   arb_port_t           r_last_grant, w_last_nxt;
   logic                w_grant_if, w_grant_dm, w_done, w_timeout, w_kill_now;
   logic                r_kill;
   logic                r_if_ack, r_dm_ack, r_bus_req, r_bus_we;
   logic [DATA_W-1:0]   r_if_rdata, r_dm_rdata, r_bus_wdata;
   logic [BE_W-1:0]     r_bus_be;
   logic [ADDR_W-1:0]   r_bus_addr;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= PORT_IF;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_nxt;
      end
   end

   // Next state, grant and completion strobes
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last_grant;
      w_grant_if  = 1'b0;
      w_grant_dm  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            // On contention the port that did not win last time is served.
            if (if_req && (!dm_req || (other_port(r_last_grant) == PORT_IF))) begin
               w_grant_if  = 1'b1;
               w_last_nxt  = PORT_IF;
               w_state_nxt = FETCH;
            end else if (dm_req) begin
               w_grant_dm  = 1'b1;
               w_last_nxt  = PORT_MEM;
               w_state_nxt = DATA;
            end
         end
         FETCH, DATA: begin
            if (bus_ack || w_timeout) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A flush seen in any FETCH cycle, including the completing one, drops the result.
   assign w_kill_now = r_kill | if_kill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kill <= 1'b0;
      end else if (w_grant_if || w_grant_dm) begin
         r_kill <= 1'b0;
      end else if ((r_state == FETCH) && if_kill) begin
         r_kill <= 1'b1;
      end
   end

   // Bus request registers: loaded on grant, held until completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_be    <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else if (w_grant_if) begin
         r_bus_req   <= 1'b1;
         r_bus_we    <= 1'b0;
         r_bus_be    <= '1;
         r_bus_addr  <= if_addr;
         r_bus_wdata <= '0;
      end else if (w_grant_dm) begin
         r_bus_req   <= 1'b1;
         r_bus_we    <= dm_we;
         r_bus_be    <= dm_be;
         r_bus_addr  <= dm_addr;
         r_bus_wdata <= dm_wdata;
      end else if (w_done) begin
         r_bus_req   <= 1'b0;
      end
   end

   // Response registers: ack is high only in RESP; rdata holds until next capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_ack   <= 1'b0;
         r_dm_ack   <= 1'b0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         if (w_done) begin
            if (r_state == FETCH) begin
               if (!w_kill_now) begin
                  r_if_ack   <= 1'b1;
                  r_if_rdata <= w_timeout ? '0 : bus_rdata;
               end
            end else begin
               r_dm_ack   <= 1'b1;
               r_dm_rdata <= w_timeout ? '0 : bus_rdata;
            end
         end
      end
   end

`ifdef CPU_MEM_ARB_TIMEOUT_EN
   logic w_busy;
   logic r_bus_err;

   assign w_busy = (r_state == FETCH) || (r_state == DATA);

   cpu_mem_arb_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_grant_if | w_grant_dm),
      .i_run     (w_busy),
      .i_ack     (bus_ack),
      .o_expired (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err <= 1'b0;
      end else if (w_timeout) begin
         r_bus_err <= 1'b1;
      end
   end

   assign bus_err = r_bus_err;
`else
   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   assign if_ack    = r_if_ack;
   assign if_rdata  = r_if_rdata;
   assign dm_ack    = r_dm_ack;
   assign dm_rdata  = r_dm_rdata;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_be    = r_bus_be;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

endmodule
